// File: rtl/inst_fetch_if.sv
// Instruction-memory port of the fetch stage: valid/ready request channel
// plus an in-order response channel.
interface inst_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  imem_rsp_err
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output imem_rsp_err
    );
endinterface

// File: rtl/inst_fetch.sv
// RV64 instruction fetch: PC, credit-limited imem reads, response buffer,
// stall/redirect handling and halt-on-fault.
module inst_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_fetch_if.master imem,
    input  logic         stall,
    input  logic         redirect_valid,
    input  logic [63:0]  redirect_pc,
    output logic         inst_valid,
    output logic [31:0]  inst,
    output logic [63:0]  inst_pc,
    output logic         inst_fault
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 6;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic {RUN, HALT} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [63:0] pc;
        logic        fault;
    } entry_t;

    entry_t             fifo [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   occ;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   stale;
    logic [63:0]        pc;
    logic [63:0]        rsp_pc;
    state_t             state;

    logic               req_valid;
    logic               req_fire;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   credit_used;
    logic [63:0]        redirect_aligned;
    entry_t             head;

    // Counting this cycle's pop as freed space keeps one fetch per cycle at DEPTH=2.
    always_comb begin
        credit_used      = outstanding - stale + occ - CNT_W'(pop);
        req_valid        = rst_n && (state == RUN) && !redirect_valid &&
                           (credit_used < CNT_W'(DEPTH));
        req_fire         = req_valid && imem.imem_req_ready;
        push             = imem.imem_rsp_valid && (stale == '0);
        pop              = inst_valid && !stall;
        redirect_aligned = {redirect_pc[63:2], 2'b00};
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = pc;

    // Head of the buffer is presented directly; NOP when nothing is live.
    always_comb begin
        head       = fifo[rd_ptr];
        inst_valid = (occ != '0);
        inst       = inst_valid ? head.data  : NOP;
        inst_pc    = inst_valid ? head.pc    : 64'd0;
        inst_fault = inst_valid ? head.fault : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occ         <= '0;
            outstanding <= '0;
            stale       <= '0;
            state       <= RUN;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo[i] <= '0;
            end
        end else begin
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(imem.imem_rsp_valid);
            if (redirect_valid) begin
                // Everything still in flight belongs to the old path.
                pc     <= redirect_aligned;
                rsp_pc <= redirect_aligned;
                rd_ptr <= '0;
                wr_ptr <= '0;
                occ    <= '0;
                stale  <= outstanding - CNT_W'(imem.imem_rsp_valid);
                state  <= RUN;
            end else begin
                if (req_fire) begin
                    pc <= pc + 64'd4;
                end
                if (imem.imem_rsp_valid && (stale != '0)) begin
                    stale <= stale - CNT_W'(1);
                end
                if (push) begin
                    fifo[wr_ptr] <= '{data: imem.imem_rsp_data, pc: rsp_pc,
                                      fault: imem.imem_rsp_err};
                    wr_ptr       <= wr_ptr + PTR_W'(1);
                    rsp_pc       <= rsp_pc + 64'd4;
                    if (imem.imem_rsp_err) begin
                        state <= HALT;
                    end
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                occ <= occ + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: imem model with random latency/backpressure
// and an instruction-stream reference model.
module tb_inst_fetch;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_fault;

    inst_fetch_if imem ();

    inst_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    mreq_t       memq [$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    // stimulus knobs
    int          p_ready, p_rsp, p_stall, p_rd, lat_max;
    bit          frc_rd;
    logic [63:0] frc_rd_pc;
    logic [63:0] fault_addr;

    // reference model
    logic [63:0] exp_req, exp_pc, first_pop_pc;
    bit          fault_seen, have_first;
    int          post_fault, pops, fires, fault_pops;

    // previous-cycle observations
    bit          prev_rd, prev_hold, prev_pend;
    logic [31:0] prev_inst;
    logic [63:0] prev_pc, prev_addr;
    logic        prev_fault;

    // obs from the latest step
    bit          obs_fire, obs_iv;
    logic [63:0] obs_addr, obs_pc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] ^ {a[15:0], 16'hC3A5};
    endfunction

    task automatic model_reset();
        memq.delete();
        exp_req = RESET_PC; exp_pc = RESET_PC;
        fault_seen = 0; post_fault = 0; have_first = 0;
        prev_rd = 0; prev_hold = 0; prev_pend = 0;
    endtask

    task automatic reset_checks();
        check("rst_req_valid", 64'(imem.imem_req_valid), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst", 64'(inst), 64'(NOP));
        check("rst_inst_pc", inst_pc, 64'd0);
        check("rst_inst_fault", 64'(inst_fault), 64'd0);
    endtask

    // Called at a negedge; asserts reset mid-phase, releases it at a later negedge.
    task automatic apply_reset(input int hold);
        #3 rst_n = 1'b0;
        #1 reset_checks();
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step();
        bit fire, pop, rd, rsp, rsp_err, v, iv;
        logic [63:0] a, ra;
        rsp = 0; rsp_err = 0; ra = '0;
        imem.imem_req_ready = (int'($urandom_range(99)) < p_ready);
        if (memq.size() > 0) begin
            if (memq[0].due <= cyc && int'($urandom_range(99)) < p_rsp) begin
                rsp = 1; ra = memq[0].addr; rsp_err = (ra == fault_addr);
            end
        end
        imem.imem_rsp_valid = rsp;
        imem.imem_rsp_data  = rsp ? word(ra) : 32'd0;
        imem.imem_rsp_err   = rsp_err;
        stall = (int'($urandom_range(99)) < p_stall);
        rd = frc_rd || (int'($urandom_range(99)) < p_rd);
        redirect_valid = rd;
        redirect_pc = frc_rd ? frc_rd_pc : RESET_PC + 64'($urandom_range(511));
        #1;
        v = imem.imem_req_valid; a = imem.imem_req_addr; iv = inst_valid;
        fire = v && imem.imem_req_ready;
        pop = iv && !stall;

        if (!iv) check("nop_when_empty", 64'(inst), 64'(NOP));
        if (rd) check("req_low_on_redirect", 64'(v), 64'd0);
        if (prev_rd) check("empty_after_redirect", 64'(iv), 64'd0);
        if (fault_seen && !rd) check("no_req_when_halted", 64'(v), 64'd0);
        if (iv && inst_fault) check("no_req_fault_head", 64'(v), 64'd0);
        if (prev_hold) begin
            check("stall_valid", 64'(iv), 64'd1);
            check("stall_inst", 64'(inst), 64'(prev_inst));
            check("stall_pc", inst_pc, prev_pc);
            check("stall_fault", 64'(inst_fault), 64'(prev_fault));
        end
        if (prev_pend && !rd) begin
            check("req_hold_valid", 64'(v), 64'd1);
            check("req_hold_addr", a, prev_addr);
        end
        if (fire) begin
            check("req_addr", a, exp_req);
            exp_req += 64'd4;
            memq.push_back('{addr: a, due: cyc + int'($urandom_range(lat_max, 1))});
            fires++;
        end
        if (rsp) void'(memq.pop_front());
        if (rd) begin
            exp_req = {redirect_pc[63:2], 2'b00};
            exp_pc = exp_req;
            fault_seen = 0; post_fault = 0;
        end else if (pop) begin
            check("inst_pc", inst_pc, exp_pc);
            check("inst_word", 64'(inst), 64'(word(exp_pc)));
            check("inst_fault", 64'(inst_fault), 64'(exp_pc == fault_addr));
            if (fault_seen) begin
                post_fault++;
                check("post_fault_bound", 64'(post_fault <= int'(DEPTH) - 1), 64'd1);
            end
            if (exp_pc == fault_addr) begin
                fault_seen = 1; fault_pops++;
            end
            if (!have_first) begin
                first_pop_pc = inst_pc; have_first = 1;
            end
            exp_pc += 64'd4;
            pops++;
        end
        prev_rd = rd;
        prev_hold = iv && stall && !rd;
        prev_inst = inst; prev_pc = inst_pc; prev_fault = inst_fault;
        prev_pend = v && !imem.imem_req_ready && !rd && !rsp_err;
        prev_addr = a;
        obs_fire = fire; obs_addr = a; obs_iv = iv; obs_pc = inst_pc;
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_knobs(input int r, input int rs, input int st, input int rdp, input int lat);
        p_ready = r; p_rsp = rs; p_stall = st; p_rd = rdp; lat_max = lat;
    endtask

    initial begin
        int n;
        imem.imem_req_ready = 0; imem.imem_rsp_valid = 0;
        imem.imem_rsp_data = '0; imem.imem_rsp_err = 0;
        stall = 0; redirect_valid = 0; redirect_pc = '0;
        frc_rd = 0; frc_rd_pc = '0; fault_addr = '1;
        pops = 0; fires = 0; fault_pops = 0;
        set_knobs(100, 100, 0, 0, 1);
        repeat (2) @(negedge clk);
        #1 reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // reset release, L=1, back-to-back requests and one inst per cycle
        for (int c = 1; c <= 8; c++) begin
            step();
            check("burst_fire", 64'(obs_fire), 64'd1);
            if (c <= 3) check("burst_addr", obs_addr, RESET_PC + 64'(4 * (c - 1)));
            check("burst_inst_valid", 64'(obs_iv), 64'(c >= 3));
            if (c >= 3) check("burst_inst_pc", obs_pc, RESET_PC + 64'(4 * (c - 3)));
        end

        // stall held five cycles
        p_stall = 100; n = fires;
        repeat (5) step();
        check("stall_credit", 64'(fires - n <= int'(DEPTH)), 64'd1);
        p_stall = 0;
        repeat (6) step();

        // redirect while two requests are outstanding
        set_knobs(100, 100, 0, 0, 3);
        for (int c = 0; c < 20 && memq.size() < 2; c++) step();
        check("two_outstanding", 64'(memq.size() >= 2), 64'd1);
        frc_rd = 1; frc_rd_pc = 64'h0000_0000_8000_0103;
        step();
        frc_rd = 0; have_first = 0;
        repeat (12) step();
        check("redirect_first_pc", first_pop_pc, 64'h0000_0000_8000_0100);

        // redirect in steady state (same cycle as a response and a pop)
        set_knobs(100, 100, 0, 0, 1);
        repeat (6) step();
        frc_rd = 1; frc_rd_pc = 64'h0000_0000_8000_0040;
        step();
        frc_rd = 0; have_first = 0;
        repeat (6) step();
        check("steady_redirect_pc", first_pop_pc, 64'h0000_0000_8000_0040);

        // access fault at RESET_PC+8, then resume by redirect
        apply_reset(2);
        fault_addr = RESET_PC + 64'd8; fault_pops = 0;
        repeat (14) step();
        check("fault_presented", 64'(fault_pops), 64'd1);
        check("fault_halted", 64'(fault_seen), 64'd1);
        frc_rd = 1; frc_rd_pc = 64'h0000_0000_8000_0200;
        step();
        frc_rd = 0; have_first = 0;
        repeat (8) step();
        check("fault_resume_pc", first_pop_pc, 64'h0000_0000_8000_0200);

        // randomized traffic
        apply_reset(1);
        fault_addr = RESET_PC + 64'(4 * $urandom_range(127));
        set_knobs(70, 70, 30, 4, 4);
        n = pops;
        repeat (3000) step();
        check("random_progress", 64'(pops - n > 100), 64'd1);

        // reset mid-burst with backpressure, then restart at RESET_PC
        set_knobs(0, 100, 0, 0, 1);
        repeat (3) step();
        apply_reset(2);
        set_knobs(100, 100, 0, 0, 1);
        step();
        check("restart_fire", 64'(obs_fire), 64'd1);
        check("restart_addr", obs_addr, RESET_PC);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
